program_loader: RTL

Hardware boot sequencer between the host/file stream, mainMem, fetch and decode. It streams a program image into main memory from a configurable base address, then releases the fetch stall and runs a fixed pipeline warm-up. It then drives the memory address from the fetch PC, supplies delayed PCs to decode and asserts valid_insn until the loaded word count has been issued. It is parametrised in address/data width, base address, depth limit and warm-up length.

---
 rtl/program_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: boot sequencer that streams a program image into mainMem,
// releases the fetch stall, runs a fixed warm-up, then issues the loaded words.
// Ports: clock/reset (sync, active-high); start; load_valid/load_data/
//   load_last/load_ready stream; mem_busy and mem_* memory request outputs;
//   fetch_pc/fetch_acc_size in; stall, pc, pc_decode, valid_insn to the core;
//   word_count, issue_count, done, error status.
// Optional: define LOADER_CHECKSUM_EN to add checksum out / expected_sum in.
module program_loader #(
   parameter int                ADDR_W        = 32,
   parameter int                DATA_W        = 32,
   parameter logic [ADDR_W-1:0] START_ADDRESS = 32'h80020000,
   parameter int                WORD_BYTES    = 4,
   parameter int                MAX_WORDS     = 1024,
   parameter int                WARMUP_CYCLES = 2,
   localparam int               CNT_W         = $clog2(MAX_WORDS+1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              mem_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_wren,
   output logic              mem_enable,
   output logic [1:0]        mem_acc_size,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic [1:0]        fetch_acc_size,
   output logic              stall,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_decode,
   output logic              valid_insn,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  issue_count,
`ifdef LOADER_CHECKSUM_EN
   input  logic [DATA_W-1:0] expected_sum,
   output logic [DATA_W-1:0] checksum,
`endif
   output logic              done,
   output logic              error
);

   localparam int WCNT_W = $clog2(WARMUP_CYCLES+1);

   typedef enum logic [2:0] {
      IDLE, LOAD, WARMUP, RUN, DONE, ERROR
   } state_t;

   state_t            state, next;
   logic              write;
   logic              start_load;
   logic              sum_ok;
   logic [WCNT_W-1:0] wcnt;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_next;
   assign sum_next = checksum + load_data;
   assign sum_ok   = (sum_next == expected_sum);
`else
   assign sum_ok = 1'b1;
`endif

   assign mem_enable = 1'b1;
   assign stall      = !(state == WARMUP || state == RUN);
   assign valid_insn = (state == RUN);
   assign start_load = start && (state == IDLE || state == DONE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next       = state;
      write      = 1'b0;
      load_ready = 1'b0;
      unique case (state)
         IDLE: if (start) next = LOAD;
         LOAD: begin
            // reset gates ready so a beat coinciding with reset is dropped
            load_ready = !mem_busy && !reset;
            if (load_valid && load_ready) begin
               if (word_count == CNT_W'(MAX_WORDS)) begin
                  next = ERROR;
               end else begin
                  write = 1'b1;
                  if (load_last) next = sum_ok ? WARMUP : ERROR;
               end
            end
         end
         WARMUP: if (wcnt == WCNT_W'(WARMUP_CYCLES-1)) next = RUN;
         RUN: if (issue_count == word_count - 1'b1) next = DONE;
         DONE: if (start) next = LOAD;
         ERROR: next = ERROR;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_addr     <= START_ADDRESS;
         mem_data_in  <= '0;
         mem_wren     <= 1'b0;
         mem_acc_size <= 2'b00;
         pc           <= START_ADDRESS;
         pc_decode    <= START_ADDRESS;
         word_count   <= '0;
         issue_count  <= '0;
         wcnt         <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum     <= '0;
`endif
      end else begin
         if (start_load) begin
            mem_addr    <= START_ADDRESS;
            mem_wren    <= 1'b0;
            word_count  <= '0;
            issue_count <= '0;
            done        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
         end
         if (write) begin
            mem_wren     <= 1'b1;
            mem_data_in  <= load_data;
            mem_acc_size <= 2'b00;
            mem_addr     <= START_ADDRESS +
                            ADDR_W'(WORD_BYTES) * ADDR_W'(word_count);
            word_count   <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= sum_next;
`endif
         end else if (state == LOAD) begin
            mem_wren <= 1'b0;
         end
         // fetch drives the memory port once the image is in place
         if (state == WARMUP || state == RUN) begin
            mem_wren     <= 1'b0;
            mem_acc_size <= fetch_acc_size;
            mem_addr     <= fetch_pc;
            pc           <= fetch_pc;
            pc_decode    <= pc;
         end
         if (state == WARMUP) wcnt <= wcnt + 1'b1;
         else                 wcnt <= '0;
         if (state == RUN) issue_count <= issue_count + 1'b1;
         if (state == RUN && next == DONE) done <= 1'b1;
         if (next == ERROR) error <= 1'b1;
      end
   end

endmodule
